// File: rtl/shift_right_pkg.sv
// Shared types and sizing helpers for the shift_right serializer.
// Holds the FSM state type, the frame-length and counter-width helpers, and
// the parity build switch (SHIFT_RIGHT_PARITY_EN) as a package constant.
package shift_right_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

`ifdef SHIFT_RIGHT_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Number of bits presented per frame: the data word plus an optional parity bit.
    function automatic int frame_len(input int width, input bit parity_en);
        return width + (parity_en ? 1 : 0);
    endfunction

    // Counter width large enough to hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_right_bitcnt.sv
// Frame bit counter: counts presented bits and flags the final one.
// Latency: clear/increment take effect on the next rising edge; tc_o is decoded from the count register.
// Backpressure: en_i low holds the count; the count saturates at TC_VAL and never wraps.
//
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset (count -> 0)
//   clr_i - clear count to 0 (priority over en_i)
//   en_i  - advance count by one
//   tc_o  - count equals TC_VAL (final frame bit is on the output)
module shift_right_bitcnt
    import shift_right_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int TC_VAL = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(TC_VAL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TC)) begin
            // Hold at the terminal value; the owner clears on frame exit.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/shift_right.sv
// Parallel-in, serial-out right-shift serializer, LSB first, with valid/last framing.
// Latency: word accepted at edge N shows bit 0 on out from N to N+1; one bit per enabled cycle.
// Backpressure: shift_en low stalls with all state held; in_ready low (load ignored) while a frame is in flight.
//
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   a, load    - parallel word and load request (taken only when in_ready)
//   in_ready   - idle, able to accept a word
//   shift_en   - advance enable for the serial stream
//   out        - serial bit (registered)
//   out_valid  - out carries a frame bit
//   out_last   - out carries the final frame bit
// Build option: SHIFT_RIGHT_PARITY_EN appends an even-parity bit after the data bits.
module shift_right
    import shift_right_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             load,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             out,
    output logic             out_valid,
    output logic             out_last
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int FRAME = frame_len(WIDTH, PARITY_EN);

    state_e           state_q;
    // Shift register spans the whole frame; with parity the parity register
    // sits above the data bits and falls into bit 0 after the last data bit.
    logic [FRAME-1:0] sreg_q;
    logic [FRAME-1:0] load_word;
    logic             accept;
    logic             advance;
    logic             tc;

`ifdef SHIFT_RIGHT_PARITY_EN
    assign load_word = {^a, a};
`else
    assign load_word = a;
`endif

    assign accept  = (state_q == IDLE) && load;
    assign advance = (state_q == SHIFT) && shift_en;

    shift_right_bitcnt #(
        .CNT_W  (CNT_W),
        .TC_VAL (FRAME - 1)
    ) u_bitcnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept || (advance && tc)),
        .en_i  (advance),
        .tc_o  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        sreg_q  <= load_word;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (tc) begin
                            // Clearing here keeps out at 0 while idle.
                            sreg_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            sreg_q <= sreg_q >> 1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sreg_q  <= '0;
                end
            endcase
        end
    end

    // All outputs come from registered state only.
    assign out       = sreg_q[0];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SHIFT);
    assign out_last  = (state_q == SHIFT) && tc;

endmodule

// File: tb/tb_shift_right.sv
// Directed bench for shift_right: reset/idle, single-bit frames, walking one,
// mid-frame stall, reset abort, and the optional parity frame.
module tb_shift_right;

`ifdef SHIFT_RIGHT_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic       load;
    logic       in_ready;
    logic       shift_en;
    logic       out;
    logic       out_valid;
    logic       out_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_right #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .load      (load),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .out       (out),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_last"},  32'(out_last),  32'd0);
        check({tag, ".out"},       32'(out),       32'd0);
    endtask

    // Load a word with shift_en held high and check every presented bit.
    // exp_bits[i] is the required out in frame cycle i+1 (index 8 = parity).
    task automatic run_frame(input string tag, input logic [7:0] word, input logic [8:0] exp_bits);
        a        = word;
        load     = 1'b1;
        shift_en = 1'b1;
        tick();
        load = 1'b0;
        a    = ~word;  // must not affect the captured frame
        for (int i = 0; i < FL; i++) begin
            check($sformatf("%s.out[%0d]", tag, i),   32'(out),       32'(exp_bits[i]));
            check($sformatf("%s.vld[%0d]", tag, i),   32'(out_valid), 32'd1);
            check($sformatf("%s.last[%0d]", tag, i),  32'(out_last),  (i == FL - 1) ? 32'd1 : 32'd0);
            check($sformatf("%s.rdy[%0d]", tag, i),   32'(in_ready),  32'd0);
            tick();
        end
        check_idle({tag, ".after"});
    endtask

    logic [7:0] stall_seq [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst      = 1'b1;
        a        = 8'h00;
        load     = 1'b1;  // reset must win over load
        shift_en = 1'b1;
        tick();
        check_idle("rst1");
        tick();
        check_idle("rst2");
        rst  = 1'b0;
        load = 1'b0;
        tick();
        check_idle("idle1");
        tick();
        check_idle("idle2");

        // Single 1 in bit 0: pulse in frame cycle 1 only.
        run_frame("lsb", 8'b0000_0001, {1'b1, 8'b0000_0001});

        // Walking one: bit k appears in frame cycle k+1; parity of one set bit is 1.
        run_frame("walk0", 8'b0000_0001, 9'b1_0000_0001);
        run_frame("walk1", 8'b0000_0010, 9'b1_0000_0010);
        run_frame("walk2", 8'b0000_0100, 9'b1_0000_0100);
        run_frame("walk3", 8'b0000_1000, 9'b1_0000_1000);
        run_frame("walk4", 8'b0001_0000, 9'b1_0001_0000);
        run_frame("walk5", 8'b0010_0000, 9'b1_0010_0000);
        run_frame("walk6", 8'b0100_0000, 9'b1_0100_0000);
        run_frame("walk7", 8'b1000_0000, 9'b1_1000_0000);

        // Stall for 3 cycles after the 4th presented bit.
        a        = 8'b1011_0010;
        load     = 1'b1;
        shift_en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stall.out[%0d]", i), 32'(out), 32'(stall_seq[i][0]));
            check($sformatf("stall.last[%0d]", i), 32'(out_last), (i == FL - 1) ? 32'd1 : 32'd0);
            if (i == 3) begin
                shift_en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check($sformatf("stall.hold[%0d]", s), 32'(out), 32'd0);
                    check($sformatf("stall.hvld[%0d]", s), 32'(out_valid), 32'd1);
                end
                shift_en = 1'b1;
            end
            tick();
        end
`ifdef SHIFT_RIGHT_PARITY_EN
        // Four ones in 10110010: even parity bit is 0.
        check("stall.par",      32'(out),      32'd0);
        check("stall.par_last", 32'(out_last), 32'd1);
        tick();
`endif
        check_idle("stall.after");

        // Reset at frame cycle 4 of 8'hFF, then an immediate new load.
        a        = 8'b1111_1111;
        load     = 1'b1;
        shift_en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        tick();
        check("abort.out4", 32'(out),       32'd1);
        check("abort.vld4", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        run_frame("post_abort", 8'b0000_0001, 9'b1_0000_0001);

`ifdef SHIFT_RIGHT_PARITY_EN
        // 1,1,1,0,0,0,0,0 then parity 1 (three ones).
        run_frame("parity", 8'b0000_0111, 9'b1_0000_0111);
`else
        run_frame("seven", 8'b0000_0111, 9'b0_0000_0111);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_right.md
# shift_right

Parallel-in, serial-out right-shift serializer. Captures a WIDTH-bit word on a load request and emits it one bit per enabled cycle, LSB first, on a single-bit registered output, with valid/last framing. Sits between a parallel datapath and a bit-serial link or test pin, driven from the single system clock domain.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (>= 2)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  parallel data word to serialize
- load  input  1  load request; accepted only when in_ready = 1
- in_ready  output  1  block idle and able to accept a word
- shift_en  input  1  advance enable; 0 stalls the serializer
- out  output  1  current serial bit (registered)
- out_valid  output  1  out carries a frame bit
- out_last  output  1  out carries the final bit of the frame

## Operation
- Two states: IDLE, SHIFT.
- IDLE: in_ready = 1, out_valid = 0, out_last = 0, out = 0. On load = 1, capture a into the shift register, present a[0] on out, clear the bit counter and go to SHIFT.
- SHIFT: in_ready = 0, out_valid = 1. When shift_en = 1, shift the register right by one with zero fill at the MSB, update out to the new LSB and increment the counter. When shift_en = 0, hold all state.
- out_last = 1 while the final frame bit is on out. When that bit is consumed (shift_en = 1), return to IDLE.
- Frame length is WIDTH bits, LSB first. out is bit i of the captured word during the i-th presented bit.
- load in SHIFT is ignored; changes on a after capture have no effect.
- Counter width is clog2(WIDTH+1). The counter never wraps within a frame.

## Timing
- Reset values: state IDLE, shift register 0, counter 0, out = 0, out_valid = 0, out_last = 0, in_ready = 1.
- rst has priority over load and shift_en in every cycle. Reset during SHIFT aborts the frame, with outputs at reset values the next cycle.
- Latency: load sampled high at edge N puts a[0] on out with out_valid = 1 from edge N through edge N+1.
- With shift_en held high, a frame occupies exactly WIDTH cycles. out_last is high in the WIDTH-th cycle.
- in_ready rises the cycle after the last bit is consumed. The minimum gap between frames is one idle cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- SHIFT_RIGHT_PARITY_EN defined: one even-parity bit (XOR of all captured bits) is appended after bit WIDTH-1. Frame length is WIDTH+1, and out_last marks the parity bit.
- SHIFT_RIGHT_PARITY_EN undefined: no parity logic, and the frame is exactly WIDTH bits.

## Structure
- Package shift_right_pkg holds:
  - the state enum (IDLE, SHIFT)
  - a function returning frame length for a given WIDTH and parity setting
  - the counter width localparam helper
- One sub-module, shift_right_bitcnt: the frame bit counter with clear, enable, and a terminal-count flag that drives out_last.
- The top level holds the FSM, the shift register and the optional parity register.

## Test plan
- Reset, then idle: rst = 1 for 2 cycles, then load = 0. Required: in_ready = 1, out_valid = 0, out = 0 throughout.
- Load 8'b00000001 with shift_en = 1. Required: out = 1,0,0,0,0,0,0,0 over 8 cycles, out_last only on the 8th, in_ready high the cycle after.
- Walk a single 1 across positions 0..7, one frame each. Required: the out pulse appears in frame cycle k+1 for bit k, and 8'b10000000 coincides with out_last.
- Load 8'b10110010, toggling shift_en low for 3 cycles mid-frame. Required: out holds during the stall, and the sequence is 0,1,0,0,1,1,0,1.
- Assert rst at frame cycle 4 of 8'b11111111. Required: all outputs at reset values the next cycle, and a new load is accepted immediately after.
- With SHIFT_RIGHT_PARITY_EN, load 8'b00000111. Required: a 9-bit frame 1,1,1,0,0,0,0,0 followed by a parity bit of 1, with out_last on the 9th cycle.
